// File: rtl/counter_pkg.sv
// Shared constants and parameter validation for the up/down modulo counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int unsigned WIDTH_MIN    = 2;
  localparam int unsigned WIDTH_MAX    = 32;
  localparam int unsigned PRESCALE_MAX = 65535;

  // True when width, modulus and prescale form a legal configuration.
  function automatic bit params_ok(input int unsigned width,
                                   input int unsigned max_val,
                                   input int unsigned prescale);
    logic [32:0] limit;
    limit = (33'd1 << width) - 33'd1;
    return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
           (max_val >= 1) && (33'(max_val) <= limit) &&
           (prescale >= 1) && (prescale <= PRESCALE_MAX);
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits a tick on every PRESCALE-th enabled edge.
module counter_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic resetn,
  input  logic count_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned  PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  // With PRESCALE=1 pre_q never leaves 0, so o_tick reduces to count_en.
  assign o_tick = count_en && (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (i_clr) begin
      pre_d = '0;
    end else if (o_tick) begin
      pre_d = '0;
    end else if (count_en) begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised up/down modulo counter with load, wrap/saturate mode,
// enable prescaler, terminal-count pulse and sticky overflow flag.
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (WIDTH >= 32) ? 32'hFFFF_FFFF
                                                  : ((32'd1 << WIDTH) - 32'd1),
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             count_en,
  input  logic             i_dir,
  input  logic             i_sat,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_ovf_clr,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_ovf
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

  if (!params_ok(WIDTH, MAX_VAL, PRESCALE)) begin : g_bad_params
    $error("counter_updown_mod: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  logic             tick;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic             ovf_q;
  logic             ovf_d;

  // Load restarts the prescaler so the next step needs a full PRESCALE window.
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk      (clk),
    .resetn   (resetn),
    .count_en (count_en),
    .i_clr    (i_load),
    .o_tick   (tick)
  );

  // Bounds are tested before the +/-1 so the count never needs a carry bit.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (i_load) begin
      count_d = (i_load_val >= MAX_C) ? MAX_C : i_load_val;
    end else if (tick) begin
      if (i_dir == DIR_UP) begin
        if (count_q < MAX_C) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          tc_d    = 1'b1;
          count_d = (i_sat == MODE_SAT) ? MAX_C : '0;
        end
      end else begin
        if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          tc_d    = 1'b1;
          count_d = (i_sat == MODE_SAT) ? '0 : MAX_C;
        end
      end
    end
  end

  // A set on the same edge beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (tc_d) begin
      ovf_d = 1'b1;
    end else if (i_ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_count = count_q;
  assign o_tc    = tc_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three configurations driven in lockstep,
// checked by a queued reference model plus hand-derived vectors.
module tb_counter_updown_mod;

  localparam int NDUT = 3;
  localparam int MAXV [NDUT] = '{255, 9, 255};
  localparam int PREV [NDUT] = '{1, 1, 4};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       count_en = 1'b0;
  logic       dir = 1'b1;
  logic       sat = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       ovf_clr = 1'b0;

  logic [NDUT-1:0][7:0] cnt_w;
  logic [NDUT-1:0]      tc_w;
  logic [NDUT-1:0]      ovf_w;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(1)) dut_a (
    .clk(clk), .resetn(resetn), .count_en(count_en), .i_dir(dir), .i_sat(sat),
    .i_load(load), .i_load_val(load_val), .i_ovf_clr(ovf_clr),
    .o_count(cnt_w[0]), .o_tc(tc_w[0]), .o_ovf(ovf_w[0]));

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(9), .PRESCALE(1)) dut_b (
    .clk(clk), .resetn(resetn), .count_en(count_en), .i_dir(dir), .i_sat(sat),
    .i_load(load), .i_load_val(load_val), .i_ovf_clr(ovf_clr),
    .o_count(cnt_w[1]), .o_tc(tc_w[1]), .o_ovf(ovf_w[1]));

  counter_updown_mod #(.WIDTH(8), .MAX_VAL(255), .PRESCALE(4)) dut_c (
    .clk(clk), .resetn(resetn), .count_en(count_en), .i_dir(dir), .i_sat(sat),
    .i_load(load), .i_load_val(load_val), .i_ovf_clr(ovf_clr),
    .o_count(cnt_w[2]), .o_tc(tc_w[2]), .o_ovf(ovf_w[2]));

  typedef struct {
    int cnt;
    bit tc;
    bit ovf;
  } exp_t;

  typedef struct {
    logic       rn, en, dr, st, ld;
    logic [7:0] lv;
    logic       clr;
    int         e_cnt;
    bit         e_tc, e_ovf;
  } vec_t;

  exp_t sb_q[$];
  int   m_cnt [NDUT];
  bit   m_tc  [NDUT];
  bit   m_ovf [NDUT];
  int   m_pre [NDUT];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference behaviour expressed in signed integer arithmetic.
  task automatic model_step(input int k, input logic rn, input logic en,
                            input logic dr, input logic st, input logic ld,
                            input logic [7:0] lv, input logic clr);
    int nxt;
    if (!rn) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_pre[k] = 0;
    end else begin
      m_tc[k] = 0;
      if (ld) begin
        m_cnt[k] = (int'(lv) > MAXV[k]) ? MAXV[k] : int'(lv);
        m_pre[k] = 0;
      end else if (en) begin
        m_pre[k]++;
        if (m_pre[k] == PREV[k]) begin
          m_pre[k] = 0;
          nxt = dr ? m_cnt[k] + 1 : m_cnt[k] - 1;
          if (nxt > MAXV[k] || nxt < 0) begin
            m_tc[k] = 1;
            if (st) nxt = m_cnt[k];
            else    nxt = (nxt < 0) ? MAXV[k] : 0;
          end
          m_cnt[k] = nxt;
        end
      end
      if (m_tc[k]) m_ovf[k] = 1;
      else if (clr) m_ovf[k] = 0;
    end
  endtask

  // One clock: drive on the falling edge, queue expectations, compare after rise.
  task automatic cyc(input logic rn, input logic en, input logic dr,
                     input logic st, input logic ld, input logic [7:0] lv,
                     input logic clr);
    exp_t e;
    @(negedge clk);
    resetn = rn; count_en = en; dir = dr; sat = st;
    load = ld; load_val = lv; ovf_clr = clr;
    for (int k = 0; k < NDUT; k++) begin
      model_step(k, rn, en, dr, st, ld, lv, clr);
      e.cnt = m_cnt[k]; e.tc = m_tc[k]; e.ovf = m_ovf[k];
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 0, 1);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("sb_cnt dut%0d", k), int'(cnt_w[k]), e.cnt);
        chk($sformatf("sb_tc dut%0d", k), int'(tc_w[k]), int'(e.tc));
        chk($sformatf("sb_ovf dut%0d", k), int'(ovf_w[k]), int'(e.ovf));
      end
    end
  endtask

  vec_t vecs [16];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0,   1'b1, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd3,   1'b0, 3, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 2, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b1, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0,   1'b0, 0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 1'b0, 9, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd5,   1'b0, 5, 1'b0, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b0, 6, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 6, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd9,   1'b0, 9, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 0, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   1'b1, 0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0,   1'b0, 9, 1'b1, 1'b1};

    for (int k = 0; k < NDUT; k++) begin
      m_cnt[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; m_pre[k] = 0;
    end

    // Reset, then 300 enabled up/wrap edges.
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("reset_cnt", int'(cnt_w[0]), 0);
    chk("reset_tc", int'(tc_w[0]), 0);
    chk("reset_ovf", int'(ovf_w[0]), 0);
    for (int i = 1; i <= 300; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      if (i == 3)   chk("pre4_cnt_c3", int'(cnt_w[2]), 0);
      if (i == 4)   chk("pre4_cnt_c4", int'(cnt_w[2]), 1);
      if (i == 255) begin
        chk("wrap_cnt255", int'(cnt_w[0]), 255);
        chk("wrap_tc255", int'(tc_w[0]), 0);
        chk("wrap_ovf255", int'(ovf_w[0]), 0);
      end
      if (i == 256) begin
        chk("wrap_cnt256", int'(cnt_w[0]), 0);
        chk("wrap_tc256", int'(tc_w[0]), 1);
        chk("wrap_ovf256", int'(ovf_w[0]), 1);
      end
      if (i == 257) begin
        chk("wrap_tc257", int'(tc_w[0]), 0);
        chk("wrap_ovf257", int'(ovf_w[0]), 1);
      end
    end
    chk("cnt_at_300", int'(cnt_w[0]), 44);
    chk("mod10_at_300", int'(cnt_w[1]), 0);
    chk("pre4_at_300", int'(cnt_w[2]), 75);

    // Hand-derived vectors for the MAX_VAL=9 instance.
    for (int i = 0; i < $size(vecs); i++) begin
      cyc(vecs[i].rn, vecs[i].en, vecs[i].dr, vecs[i].st, vecs[i].ld,
          vecs[i].lv, vecs[i].clr);
      chk($sformatf("vec%0d_cnt", i), int'(cnt_w[1]), vecs[i].e_cnt);
      chk($sformatf("vec%0d_tc", i), int'(tc_w[1]), int'(vecs[i].e_tc));
      chk($sformatf("vec%0d_ovf", i), int'(ovf_w[1]), int'(vecs[i].e_ovf));
    end

    // Prescaler: load clears it, then 5 enabled, 3 idle, 3 enabled.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      chk($sformatf("pre_en%0d", i), int'(cnt_w[2]), (i >= 4) ? 1 : 0);
    end
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      chk($sformatf("pre_hold%0d", i), int'(cnt_w[2]), 1);
    end
    for (int i = 6; i <= 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      chk($sformatf("pre_en%0d", i), int'(cnt_w[2]), (i == 8) ? 2 : 1);
    end

    // Reset mid-count at 0x7A while enabled, then restart.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7A, 1'b0);
    chk("load_7a", int'(cnt_w[0]), 122);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    chk("midrst_cnt", int'(cnt_w[0]), 0);
    chk("midrst_tc", int'(tc_w[0]), 0);
    chk("midrst_ovf_b", int'(ovf_w[1]), 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
      chk($sformatf("post_rst_a%0d", i), int'(cnt_w[0]), i);
      chk($sformatf("post_rst_c%0d", i), int'(cnt_w[2]), (i == 4) ? 1 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_updown_mod.md
# counter_updown_mod

Parametrised up/down modulo counter; the next generation of the team's 8-bit enable-gated `counter`. It adds configurable width and modulus, count direction, synchronous load, a wrap-or-saturate mode, an enable prescaler, and terminal-count/overflow flags. It is a standalone timing/event-count primitive for the team's test and control blocks.

## Interface
- `WIDTH`, 8: counter width in bits (2..32).
- `MAX_VAL`, 2**WIDTH-1: highest count value; the count range is 0..MAX_VAL (1 <= MAX_VAL <= 2**WIDTH-1).
- `PRESCALE`, 1: number of enabled cycles per count step (1..65535).
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: reset, synchronous, active-low.
- `count_en` in 1: count enable; qualifies the prescaler.
- `i_dir` in 1: 1 = up, 0 = down.
- `i_sat` in 1: 1 = saturate at the bound, 0 = wrap modulo MAX_VAL+1.
- `i_load` in 1: synchronous load strobe.
- `i_load_val` in WIDTH: load value.
- `i_ovf_clr` in 1: clears sticky `o_ovf`.
- `o_count` out WIDTH: current count, registered.
- `o_tc` out 1: one-cycle terminal-count pulse, registered.
- `o_ovf` out 1: sticky overflow/underflow flag, registered.

## Operation
- Priority per edge: reset > load > step > hold.
- Reset (`resetn`=0 at the edge):
  - `o_count`=0, `o_tc`=0, `o_ovf`=0, prescaler=0.
  - All other inputs are ignored.
- Load:
  - `o_count` <= min(`i_load_val`, MAX_VAL).
  - Prescaler is cleared to 0.
  - `o_tc`=0 in the following cycle.
  - The load overrides a step occurring on the same edge.
- Prescaler:
  - Internal counter `pre`, 0..PRESCALE-1.
  - It advances only on edges where `count_en`=1.
  - A step occurs on an edge where `count_en`=1 and `pre`==PRESCALE-1; `pre` then returns to 0.
  - When `count_en`=0, `pre` holds; it is not cleared.
  - With PRESCALE=1, every enabled edge is a step.
- Step, up:
  - If count < MAX_VAL: count+1.
  - Else, wrap mode: count <= 0, `o_tc`=1.
  - Else, saturate mode: count holds at MAX_VAL, `o_tc`=1.
- Step, down:
  - If count > 0: count-1.
  - Else, wrap mode: count <= MAX_VAL, `o_tc`=1.
  - Else, saturate mode: count holds at 0, `o_tc`=1.
- `o_tc` is 0 on every edge with no boundary step.
- `o_ovf` flag:
  - Set on any edge that asserts `o_tc`.
  - Cleared by `i_ovf_clr`=1 only when no set occurs on the same edge; set wins.
  - Load does not clear it.
- `i_dir` and `i_sat` are sampled per edge and may change at any time; they affect only the step taken on that edge.
- Arithmetic: compare against MAX_VAL before incrementing, so no WIDTH+1 carry is needed and the count never leaves 0..MAX_VAL.

## Timing
- All outputs are registered. Latency from input sample to output change is one edge.
- `o_count` reflects a step or load on the clock edge following the cycle where the qualifying input was high.
- `o_tc` is high in exactly the cycle in which `o_count` first shows the wrapped value (wrap mode) or the held bound (saturate mode).
- In saturate mode, `o_tc` pulses on every blocked step, not just the first.
- `o_ovf` rises in the same cycle as `o_tc`.
- Steady enable with PRESCALE=P: one step every P cycles. With WIDTH=8 and MAX_VAL=255 wrapping up from 0, `o_tc` fires every 256·P cycles.
- Reset mid-count: outputs read 0 on the cycle after the reset edge. The first step after release follows PRESCALE enabled edges.

## Structure
- Shared package `counter_pkg`:
  - `DIR_UP` = 1'b1, `DIR_DOWN` = 1'b0.
  - `MODE_WRAP` = 1'b0, `MODE_SAT` = 1'b1.
  - Parameter-check function (MAX_VAL range, PRESCALE >= 1).
- Sub-module `counter_prescaler`:
  - Parameter PRESCALE; ports `clk`, `resetn`, `count_en`, `i_clr`, output `o_tick`.
  - Width is $clog2(PRESCALE) with a minimum of 1.
  - When PRESCALE=1 it degenerates to `o_tick` = `count_en`.
- Top level: the count register, next-state logic, and the tc/ovf registers.

## Test plan
- WIDTH=8, MAX_VAL=255, PRESCALE=1, up, wrap; `resetn` low for 10 cycles, then `count_en`=1 for 300 cycles -> count 0..255, then 0 at cycle 256 with `o_tc`=1 for that one cycle; `o_ovf`=1 from then on; count reaches 44 at cycle 300.
- MAX_VAL=9, down, saturate; load 3, enable 6 cycles -> 2,1,0,0,0,0; `o_tc`=1 on each of the last 3 cycles; `o_ovf` set.
- MAX_VAL=9, load `i_load_val`=200 -> `o_count`=9. Load 5 with `count_en`=1 on the same edge -> 5, not 6.
- PRESCALE=4, up; enable 5 cycles, disable 3, enable 3 -> count steps to 1 after 4 enabled edges and to 2 after the 8th enabled edge; holds while disabled.
- `i_ovf_clr`=1 on the same edge as a wrap -> `o_ovf` stays 1. Clear on the next edge -> `o_ovf`=0.
- Assert `resetn`=0 mid-count at value 0x7A with `count_en`=1 -> next cycle `o_count`=0, `o_tc`=0, `o_ovf`=0; after release, the first increment follows PRESCALE enabled edges.
